// File: rtl/cla_seq_pkg.sv
// Shared types for the multi-precision CLA sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORDS = 4;

  // Word index width, never narrower than one bit.
  function automatic int idx_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

  localparam int IDX_W = idx_width(DEF_WORDS);

endpackage

// File: rtl/cla_seq_ctrl_cla.sv
// Single-word carry-lookahead adder; every carry is a flat sum of generate terms.
module cla_seq_ctrl_cla #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              cin,
  output logic [DWIDTH-1:0] sum,
  output logic              cout
);

  logic [DWIDTH-1:0] g;
  logic [DWIDTH-1:0] p;
  logic [DWIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic acc;
    logic prop;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DWIDTH; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & cin);
    end
  end

  assign sum  = p ^ c[DWIDTH-1:0];
  assign cout = c[DWIDTH];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one CLA word per cycle, LS word first.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*DWIDTH-1:0] in_a,
  input  logic [WORDS*DWIDTH-1:0] in_b,
  input  logic                    in_sub,
  input  logic                    in_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*DWIDTH-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf,
  output logic                    busy,
  output state_t                  dbg_state
);

  localparam int W    = WORDS * DWIDTH;
  localparam int IDXW = idx_width(WORDS);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here are decoded from state only.
  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [W-1:0]      a_q, b_q, res_q;
  logic              carry_q;
  logic              last;
  logic [DWIDTH-1:0] cla_sum;
  logic              cla_cout;

  assign last = (idx_q == IDXW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  cla_seq_ctrl_cla #(.DWIDTH(DWIDTH)) u_cla (
    .a    (a_q[int'(idx_q)*DWIDTH +: DWIDTH]),
    .b    (b_q[int'(idx_q)*DWIDTH +: DWIDTH]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Subtract is A + ~B + 1, so B is inverted once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? 1'b1 : in_cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      res_q[int'(idx_q)*DWIDTH +: DWIDTH] <= cla_sum;
      carry_q <= cla_cout;
      if (!last) idx_q <= idx_q + 1'b1;
    end
  end

  assign out_sum   = res_q;
  assign out_cout  = carry_q;
  assign out_ovf   = (a_q[W-1] ~^ b_q[W-1]) & (a_q[W-1] ^ res_q[W-1]);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl at DWIDTH=8, WORDS=4.
module tb_cla_seq_ctrl;
  import cla_seq_pkg::*;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;
  state_t       dbg_state;

  int total = 0;
  int bad   = 0;
  vec_t tbl[8];

  cla_seq_ctrl #(.DWIDTH(DW), .WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic and signed range test.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] s, output logic co,
                       output logic ov);
    logic [W:0] full;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      co   = ~full[W];
      t    = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      co   = full[W];
      t    = sa + sb + longint'(cin);
    end
    s  = full[W-1:0];
    ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    in_sub = 1'($urandom); in_cin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input logic [W-1:0] es,
                       input logic eco, input logic eov, input int bp);
    int lat;
    send_op(a, b, sub, cin);
    wait_done(lat);
    check({nm, "_latency"}, lat, NW);
    repeat (bp) begin
      @(posedge clk); #1;
    end
    check({nm, "_sum"}, out_sum, es);
    check({nm, "_cout"}, out_cout, eco);
    check({nm, "_ovf"}, out_ovf, eov);
    release_result();
    check({nm, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es, held;
    logic rs, rc, eco, eov;
    int lat, seen;

    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[7] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000D, 1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_ready_valid_busy", {in_ready, out_valid, busy}, 3'b100);
    check("rst_sum", out_sum, 0);
    check("rst_cout_ovf", {out_cout, out_ovf}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
            tbl[i].s, tbl[i].co, tbl[i].ov, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = ~ra;
      rs = 1'($urandom); rc = 1'($urandom);
      model(ra, rb, rs, rc, es, eco, eov);
      do_op($sformatf("rand%0d", i), ra, rb, rs, rc, es, eco, eov, $urandom_range(0, 2));
    end

    // Backpressure: hold DONE while offering new operands
    model(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b1, es, eco, eov);
    send_op(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b1);
    wait_done(lat);
    check("bp_latency", lat, NW);
    held = out_sum;
    check("bp_sum", held, es);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_flags", k), {out_valid, in_ready, busy}, 3'b101);
      check($sformatf("bp_hold%0d_out", k), {out_sum, out_cout, out_ovf}, {es, eco, eov});
    end
    in_valid = 1'b0;
    release_result();
    check("bp_released_idle", {out_valid, in_ready, dbg_state}, {2'b01, IDLE});
    send_op(32'h00000003, 32'h00000004, 1'b0, 1'b0);
    check("bp_next_accepted", busy, 1);
    wait_done(lat);
    check("bp_next_sum", out_sum, 32'h00000007);
    release_result();

    // Asynchronous reset mid-RUN at idx=2
    send_op(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_flags", {in_ready, out_valid, busy}, 3'b100);
    check("midrun_rst_outs", {out_sum, out_cout, out_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrun_no_result", seen, 0);
    do_op("after_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
